// File: rtl/uart_rx_if.sv
// Holding-register handshake between the UART receiver and the bus-side register block.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling baudtick strobe.
// Received bytes land in a valid/ready holding register; framing and overrun errors pulse for one clk.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudtick,
  input  logic       rx,
  uart_rx_if.master  rxo,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = '1;
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 complete;

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    if (baudtick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_MID) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          // tick_cnt wraps to zero on its own after TICK_LAST
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == LAST_BIT) state_d = S_STOP;
          end
        end
        S_STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            if (rx_s_q) begin
              complete = 1'b1;
              state_d  = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A completion in the same clk as a consumer accept reloads rather than clears.
    if (complete) begin
      if (!valid_q || rxo.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rxo.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rxo.rx_data  = data_q;
  assign rxo.rx_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level stimulus predicts delivered bytes and error pulses,
// an independent monitor checks them as the DUT presents them.
module tb_uart_rx;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;
  // start detect -> completion: half start bit + 8 data bits + stop bit, in ticks
  localparam int FRAME_TICKS = 8 + 16 * 8 + 16;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic baudtick;
  logic rx;
  logic frame_err, overrun, busy;

  uart_rx_if #(.DATA_BITS(8)) rxif ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .baudtick (baudtick),
    .rx       (rx),
    .rxo      (rxif),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   tick_no = 0;
  exp_t dq[$];
  int   eq[$];
  bit   held = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // baudtick: one clk high out of every four, changed away from the active edge
  initial begin
    baudtick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baudtick = 1'b1;
      @(negedge clk);
      baudtick = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (baudtick) tick_no++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an error pulse.
  initial begin
    bit   valid_prev = 1'b0;
    int   rise_tick = 0;
    int   rise_busy = 0;
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_prev = 1'b0;
      end else begin
        if (rxif.rx_valid && !valid_prev) begin
          rise_tick = tick_no;
          rise_busy = int'(busy);
        end
        valid_prev = rxif.rx_valid;
        if (rxif.rx_valid && rxif.rx_ready) begin
          if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rxif.rx_data);
          end else begin
            e = dq.pop_front();
            chk("rx_data", int'(rxif.rx_data), int'(e.d));
            chk("valid_tick", rise_tick, e.t);
            chk("busy_at_valid", rise_busy, 0);
          end
        end
        if (frame_err) begin
          if (eq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame_err: got pulse, expected none");
          end else begin
            k = eq.pop_front();
            chk("frame_err_event", EV_FERR, k);
          end
        end
        if (overrun) begin
          if (eq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_overrun: got pulse, expected none");
          end else begin
            k = eq.pop_front();
            chk("overrun_event", EV_OVR, k);
          end
        end
      end
    end
  end

  // Returns just after the next baudtick edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!baudtick);
      #1;
    end
  endtask

  // Frame-level reference: what the holding register and error outputs must do for this frame.
  task automatic predict(input logic [7:0] d, input bit stop_ok, input int exp_tick);
    exp_t e;
    if (!stop_ok) begin
      eq.push_back(EV_FERR);
    end else if (held) begin
      eq.push_back(EV_OVR);
    end else begin
      e.d = d;
      e.t = exp_tick;
      dq.push_back(e);
      held = !rxif.rx_ready;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    predict(d, stop_ok, tick_no + 1 + FRAME_TICKS);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop_ok;
    wait_ticks(16);
  endtask

  initial begin
    int         seen;
    logic [7:0] rd;
    bit         ok;

    reset = 1'b1;
    rx = 1'b1;
    rxif.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_valid", int'(rxif.rx_valid), 0);
    chk("reset_rx_data", int'(rxif.rx_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Idle line
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      wait_ticks(1);
      if (busy || rxif.rx_valid || frame_err || overrun) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Single byte with consumer ready
    rxif.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);

    // Back-to-back with consumer stalled: second byte overruns
    rxif.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    chk("ovr_valid_held", int'(rxif.rx_valid), 1);
    chk("ovr_data_kept", int'(rxif.rx_data), 8'h3C);
    rxif.rx_ready = 1'b1;
    held = 1'b0;
    @(posedge clk);
    #1;
    rxif.rx_ready = 1'b0;
    chk("ovr_valid_cleared", int'(rxif.rx_valid), 0);
    rxif.rx_ready = 1'b1;
    wait_ticks(2);

    // Low stop bit, then a held-low line
    send_frame(8'h55, 1'b0);
    wait_ticks(40);
    chk("break_busy", int'(busy), 1);
    chk("break_no_valid", int'(rxif.rx_valid), 0);
    rx = 1'b1;
    wait_ticks(3);
    chk("break_exit_busy", int'(busy), 0);
    send_frame(8'h81, 1'b1);
    wait_ticks(3);

    // Short glitch on an idle line
    rx = 1'b0;
    wait_ticks(2);
    chk("glitch_busy", int'(busy), 1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    chk("glitch_busy_after", int'(busy), 0);
    chk("glitch_no_valid", int'(rxif.rx_valid), 0);

    // Reset mid-frame with a byte already held
    rxif.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    rd = 8'h96;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      wait_ticks(16);
    end
    wait_ticks(5);
    reset = 1'b1;
    dq.delete();
    held = 1'b0;
    #1;
    chk("midreset_rx_valid", int'(rxif.rx_valid), 0);
    chk("midreset_rx_data", int'(rxif.rx_data), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    chk("midreset_overrun", int'(overrun), 0);
    rx = 1'b1;
    wait_ticks(2);
    reset = 1'b0;
    rxif.rx_ready = 1'b1;
    wait_ticks(3);
    send_frame(8'hF0, 1'b1);
    wait_ticks(3);

    // Random frames, gaps and occasional bad stop bits
    for (int n = 0; n < 14; n++) begin
      rd = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(rd, ok);
      if (!ok) begin
        wait_ticks($urandom_range(0, 20));
        rx = 1'b1;
        wait_ticks($urandom_range(2, 4));
      end else begin
        rx = 1'b1;
        wait_ticks($urandom_range(0, 3));
      end
    end

    rx = 1'b1;
    wait_ticks(20);
    chk("bytes_outstanding", dq.size(), 0);
    chk("errors_outstanding", eq.size(), 0);
    chk("final_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Sits directly downstream of the baud-rate generator.
- Consumes that block's 16x-oversampling baudtick strobe to recover bytes from the asynchronous serial input line.
- Delivers each received byte on a valid/ready holding-register interface to the bus-side register block.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first; legal range 5..8.
- OVERSAMPLE, 16, baudticks per bit period; must be a power of two, at least 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- baudtick  input  1  one-clk strobe from the baud generator, OVERSAMPLE per bit period.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready at a clk edge.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: a completed byte was dropped.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. The clock port is named clk and the reset port is named reset.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops=1, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is generated and any held byte is discarded.
- Synchroniser: rx passes through 2 flops to produce rx_s. All FSM decisions use rx_s. Latency from rx to rx_s is 2 clk.
- The FSM advances only on clk edges where baudtick=1. Between ticks all counters hold.
- tick_cnt is log2(OVERSAMPLE) bits wide and wraps naturally. bit_cnt is 3 bits.
- IDLE:
  - On baudtick with rx_s=0: go to START, tick_cnt=0.
- START:
  - Each baudtick increments tick_cnt.
  - On the tick where tick_cnt=OVERSAMPLE/2-1 (7): if rx_s=0, go to DATA with tick_cnt=0, bit_cnt=0.
  - If rx_s=1 at that tick, it is a glitch: return to IDLE with no error.
- DATA:
  - On the tick where tick_cnt=OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift, LSB first), clear tick_cnt, increment bit_cnt.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - On the tick where tick_cnt=OVERSAMPLE-1: if rx_s=1, the byte completes; go to IDLE.
  - If rx_s=0: pulse frame_err for 1 clk, discard the byte, go to BREAK.
- BREAK:
  - On baudtick with rx_s=1: go to IDLE.
  - This prevents a held-low line from retriggering START.
- Byte completion (same clk as the STOP decision):
  - rx_valid=0: load rx_data, set rx_valid.
  - rx_valid=1 and rx_ready=1 in the same clk: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: keep the old byte, pulse overrun for 1 clk, drop the new byte.
- Handshake:
  - rx_valid & rx_ready with no completion in the same clk: rx_valid clears next edge.
  - rx_data is unchanged until reloaded.
  - rx_ready while rx_valid=0 has no effect.
- Timing:
  - rx_valid rises at the edge of the 8+16*DATA_BITS+16 = 152nd baudtick after the tick that detected the start bit (defaults).
  - Stop-bit sampling occurs mid-bit, so back-to-back frames with no idle gap are received correctly.
- Errors are never sticky. frame_err and overrun cannot both fire for the same frame.

Test Plan:
- Reset, then a baudtick every 4 clk, rx=1 for 100 ticks -> rx_valid, busy, frame_err and overrun all stay 0; state remains IDLE.
- Send 0xA5 as 8N1 (16 ticks/bit), rx_ready=1 -> rx_data=0xA5; rx_valid high for exactly 1 clk at the 152nd tick after start detect; busy falls at the same edge.
- Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data=0x3C, rx_valid=1; 1-clk overrun pulse at the second completion; rx_data still 0x3C. Then rx_ready=1 for 1 clk -> rx_valid=0.
- Send 0x55 with the stop bit driven low, then hold rx=0 for 40 ticks -> 1-clk frame_err pulse, rx_valid stays 0, busy stays 1 in BREAK; rx=1 returns to IDLE, and a following 0x81 is received correctly.
- Drive a 4-tick low glitch on idle rx -> START is aborted at tick 7 with no error, no rx_valid, and busy returns to 0.
- Assert reset at data bit 3 of a frame -> all outputs 0 immediately. Release reset and send 0xF0 -> rx_data=0xF0 with no spurious frame_err.
